// File: rtl/risc_toy_fetch_queue.sv
// risc_toy_fetch_queue: instruction fetch with a credit-based prefetch FIFO and redirect flush
module risc_toy_fetch_queue #(
    parameter int AW = 30,
    parameter int DW = 32,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         IREQ,
    output logic [AW-1:0]                IADDR,
    input  logic [DW-1:0]                INSTR,
    input  logic                         REDIR,
    input  logic [AW-1:0]                REDIR_ADDR,
    output logic                         ID_VALID,
    output logic [DW-1:0]                ID_INSTR,
    output logic [AW-1:0]                ID_IADDR,
    input  logic                         ID_READY,
    output logic [$clog2(DEPTH+1)-1:0]   FQ_LEVEL
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW+AW-1:0] mem_q [DEPTH];
    logic [LW:0] credit;
    logic push, pop;

    assign ID_VALID = !RST && level_q != '0;
    assign pop = ID_VALID && ID_READY;
    // A slot freed by this cycle's pop can be reissued immediately, keeping DEPTH=2 at full rate
    assign credit = {1'b0, level_q} + (LW+1)'(inflight_q) - (LW+1)'(pop);
    assign IREQ = !RST && !REDIR && credit < (LW+1)'(DEPTH);
    assign push = inflight_q && !REDIR && !RST;
    assign IADDR = RST ? RESET_PC : pc_q;
    assign {ID_INSTR, ID_IADDR} = mem_q[rd_ptr_q];
    assign FQ_LEVEL = level_q;

    always_comb begin
        pc_d = REDIR ? REDIR_ADDR : pc_q + AW'(IREQ);
        inflight_d = IREQ;
        req_addr_d = pc_q;
        wr_ptr_d = REDIR ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = REDIR ? '0 : rd_ptr_q + PW'(pop);
        level_d = REDIR ? '0 : level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
        end else begin
            pc_q <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {INSTR, req_addr_q};
    end

    assert property (@(posedge CLK) disable iff (RST) !(push && !pop && level_q == LW'(DEPTH)));
endmodule
